// File: rtl/multi_line_stream_prefetcher.sv
// multi_line_stream_prefetcher
//   Next-N-line prefetcher for the cache miss path. Each accepted miss
//   starts a generator that walks up to PF_DEGREE sequential lines after the
//   missing line. Lines already pushed recently are skipped. The rest go into
//   a small request FIFO that drains to the memory arbiter over valid/ready.
//
// Ports
//   clk_i             clock
//   rst_ni            synchronous active-low reset
//   flush_i           drop all queued and in-flight prefetch work
//   enable_i          gate for accepting new misses (the queue still drains)
//   cache_miss_i      a miss occurred this cycle
//   miss_addr_i       byte address of the miss
//   cache_busy_i      hold off issue this cycle
//   prefetch_ready_i  arbiter accepts the head request
//   prefetch_valid_o  head request valid
//   prefetch_addr_o   head request line address (line aligned, 0 when empty)
//   occupancy_o       current FIFO entry count
module multi_line_stream_prefetcher #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned BLK_SIZE         = 128,
  parameter int unsigned PF_DEGREE        = 2,
  parameter int unsigned QUEUE_DEPTH      = 4,
  parameter int unsigned FILTER_ENTRIES   = 8,
  parameter int unsigned PAGE_BYTES       = 4096,
  parameter bit          ALLOW_PAGE_CROSS = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             enable_i,
  input  logic                             cache_miss_i,
  input  logic [XLEN-1:0]                  miss_addr_i,
  input  logic                             cache_busy_i,
  input  logic                             prefetch_ready_i,
  output logic                             prefetch_valid_o,
  output logic [XLEN-1:0]                  prefetch_addr_o,
  output logic [$clog2(QUEUE_DEPTH):0]     occupancy_o
);

  localparam int unsigned LINE_BYTES     = BLK_SIZE / 8;
  localparam int unsigned OFFSET_BITS    = $clog2(LINE_BYTES);
  localparam int unsigned LINE_W         = XLEN - OFFSET_BITS;
  localparam int unsigned PAGE_LINE_BITS = $clog2(PAGE_BYTES) - OFFSET_BITS;
  localparam int unsigned PAGE_W         = LINE_W - PAGE_LINE_BITS;
  localparam int unsigned PTR_W          = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W          = PTR_W + 1;
  localparam int unsigned FIDX_W         = $clog2(FILTER_ENTRIES);
  localparam int unsigned REM_W          = 4;

  typedef enum logic {IDLE, GEN} gen_state_e;

  gen_state_e              state_reg, state_next;
  logic [LINE_W-1:0]       cand_reg, cand_next;
  logic                    wrap_reg, wrap_next;   // cand_reg overflowed the address space
  logic [REM_W-1:0]        rem_reg, rem_next;
  logic [PAGE_W-1:0]       page_reg, page_next;
  logic [LINE_W-1:0]       last_line_reg;
  logic                    last_valid_reg;
  logic [FIDX_W-1:0]       filt_ptr_reg;
  logic [LINE_W-1:0]       filt_line_reg [FILTER_ENTRIES];
  logic                    filt_valid_reg [FILTER_ENTRIES];
  logic [FILTER_ENTRIES-1:0] filt_match;
  logic [LINE_W-1:0]       fifo_mem_reg [QUEUE_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg, count_next;

  logic [LINE_W-1:0]       miss_line;
  logic [LINE_W:0]         miss_inc, cand_inc;
  logic                    miss_acc, filt_hit, stop, can_push, push, pop, empty;
  logic                    unused_offset;

  assign miss_line     = miss_addr_i[XLEN-1:OFFSET_BITS];
  assign unused_offset = ^miss_addr_i[OFFSET_BITS-1:0];
  // One extra bit catches the +1 line increment wrapping past the top of memory.
  assign miss_inc      = {1'b0, miss_line} + (LINE_W+1)'(1);
  assign cand_inc      = {1'b0, cand_reg} + (LINE_W+1)'(1);

  // A repeat miss to the same line as the last accepted one is ignored.
  assign miss_acc = cache_miss_i && enable_i && !flush_i &&
                    !(last_valid_reg && (miss_line == last_line_reg));

  genvar gi;
  generate
    for (gi = 0; gi < FILTER_ENTRIES; gi++) begin : g_filter
      assign filt_match[gi] = filt_valid_reg[gi] && (filt_line_reg[gi] == cand_reg);

      always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
          filt_valid_reg[gi] <= 1'b0;
          filt_line_reg[gi]  <= '0;
        end else if (push && (filt_ptr_reg == FIDX_W'(gi))) begin
          filt_valid_reg[gi] <= 1'b1;
          filt_line_reg[gi]  <= cand_reg;
        end
      end
    end
  endgenerate

  assign filt_hit = |filt_match;
  assign stop     = wrap_reg ||
                    (!ALLOW_PAGE_CROSS && (cand_reg[LINE_W-1:PAGE_LINE_BITS] != page_reg));

  assign empty            = (count_reg == '0);
  assign prefetch_valid_o = !empty && !cache_busy_i;
  assign prefetch_addr_o  = empty ? '0 : {fifo_mem_reg[rd_ptr_reg], {OFFSET_BITS{1'b0}}};
  assign occupancy_o      = count_reg;

  assign pop      = prefetch_valid_o && prefetch_ready_i && !flush_i;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign can_push = (count_reg != CNT_W'(QUEUE_DEPTH)) || pop;

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    wrap_next  = wrap_reg;
    rem_next   = rem_reg;
    page_next  = page_reg;
    push       = 1'b0;
    if (miss_acc) begin
      // A new miss restarts the walk; the candidate in flight is dropped.
      state_next = GEN;
      cand_next  = miss_inc[LINE_W-1:0];
      wrap_next  = miss_inc[LINE_W];
      rem_next   = REM_W'(PF_DEGREE);
      page_next  = miss_line[LINE_W-1:PAGE_LINE_BITS];
    end else if (state_reg == GEN) begin
      if (stop) begin
        state_next = IDLE;
      end else if (filt_hit || can_push) begin
        push      = !filt_hit && !flush_i;
        cand_next = cand_inc[LINE_W-1:0];
        wrap_next = cand_inc[LINE_W];
        rem_next  = rem_reg - REM_W'(1);
        if (rem_reg == REM_W'(1)) begin
          state_next = IDLE;
        end
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_reg      <= IDLE;
      cand_reg       <= '0;
      wrap_reg       <= 1'b0;
      rem_reg        <= '0;
      page_reg       <= '0;
      last_line_reg  <= '0;
      last_valid_reg <= 1'b0;
      filt_ptr_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      wrap_reg  <= wrap_next;
      rem_reg   <= rem_next;
      page_reg  <= page_next;
      count_reg <= count_next;
      if (miss_acc) begin
        last_line_reg  <= miss_line;
        last_valid_reg <= 1'b1;
      end
      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
        filt_ptr_reg <= (filt_ptr_reg == FIDX_W'(FILTER_ENTRIES - 1)) ? '0
                                                                      : filt_ptr_reg + FIDX_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Queue storage carries no reset; entries are only visible through count_reg.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      fifo_mem_reg[wr_ptr_reg] <= cand_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!$isunknown(state_reg));
      assert (count_reg <= CNT_W'(QUEUE_DEPTH));
      assert (!prefetch_valid_o || (prefetch_addr_o[OFFSET_BITS-1:0] == '0));
    end
  end

endmodule

// File: tb/tb_multi_line_stream_prefetcher.sv
module tb_multi_line_stream_prefetcher;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        cache_miss_i = 1'b0;
  logic [31:0] miss_addr_i = '0;
  logic        cache_busy_i = 1'b0;
  logic        prefetch_ready_i = 1'b0;
  logic        valid_a, valid_b;
  logic [31:0] addr_a, addr_b;
  logic [2:0]  occ_a, occ_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  multi_line_stream_prefetcher #(.ALLOW_PAGE_CROSS(1'b0)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .enable_i(enable_i),
    .cache_miss_i(cache_miss_i), .miss_addr_i(miss_addr_i), .cache_busy_i(cache_busy_i),
    .prefetch_ready_i(prefetch_ready_i), .prefetch_valid_o(valid_a),
    .prefetch_addr_o(addr_a), .occupancy_o(occ_a)
  );

  multi_line_stream_prefetcher #(.ALLOW_PAGE_CROSS(1'b1)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .enable_i(enable_i),
    .cache_miss_i(cache_miss_i), .miss_addr_i(miss_addr_i), .cache_busy_i(cache_busy_i),
    .prefetch_ready_i(prefetch_ready_i), .prefetch_valid_o(valid_b),
    .prefetch_addr_o(addr_b), .occupancy_o(occ_b)
  );

  typedef struct {
    logic        miss;
    logic [31:0] addr;
    logic        en;
    logic        busy;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [2:0]  exp_occ;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  function automatic vec_t mk(input logic m, input logic [31:0] a, input logic en,
                              input logic busy, input logic rdy, input logic ev,
                              input logic [31:0] ea, input logic [2:0] eo);
    vec_t v;
    v.miss = m; v.addr = a; v.en = en; v.busy = busy; v.rdy = rdy;
    v.exp_valid = ev; v.exp_addr = ea; v.exp_occ = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic cycle_in(input logic m, input logic [31:0] a, input logic f);
    @(negedge clk_i);
    cache_miss_i = m;
    miss_addr_i  = a;
    flush_i      = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; flush_i = 1'b0; cache_miss_i = 1'b0; miss_addr_i = '0;
    cache_busy_i = 1'b0; prefetch_ready_i = 1'b0; enable_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic collect(input int n);
    qa.delete();
    qb.delete();
    for (int k = 0; k < n; k++) begin
      cycle_in(1'b0, 32'h0, 1'b0);
      if (valid_a) begin
        qa.push_back(addr_a);
        $display("issue A addr=%h", addr_a);
      end
      if (valid_b) begin
        qb.push_back(addr_b);
        $display("issue B addr=%h", addr_b);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] order_exp [6];
    int idx;

    // Basic two-line burst, repeat-line suppression, filter, enable gate, busy hold.
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(1, 32'h1004, 1, 0, 1, 0, 32'h0,    3'd0)); // t
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0)); // t+1 push 0x1010
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 1, 32'h1010, 3'd1)); // t+2
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 1, 32'h1020, 3'd1)); // t+3
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(1, 32'h100C, 1, 0, 1, 0, 32'h0,    3'd0)); // same line, ignored
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(1, 32'h1014, 1, 0, 1, 0, 32'h0,    3'd0)); // 0x1020 filtered
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0)); // push 0x1030
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 1, 32'h1030, 3'd1));
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(1, 32'h3000, 0, 0, 1, 0, 32'h0,    3'd0)); // enable low
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(1, 32'h2000, 1, 1, 1, 0, 32'h0,    3'd0)); // busy held
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, 0, 32'h0,    3'd0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, 0, 32'h2010, 3'd1));
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, 0, 32'h2010, 3'd2));
    vecs.push_back(mk(0, 32'h0,    1, 1, 1, 0, 32'h2010, 3'd2));
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 1, 32'h2010, 3'd2)); // busy released
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 1, 32'h2020, 3'd1));
    vecs.push_back(mk(0, 32'h0,    1, 0, 1, 0, 32'h0,    3'd0));

    do_reset();
    chk("reset_valid", {31'b0, valid_a}, 32'h0);
    chk("reset_addr", addr_a, 32'h0);
    chk("reset_occ", {29'b0, occ_a}, 32'h0);
    chk("reset_occ_b", {29'b0, occ_b}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      cache_miss_i = vecs[i].miss; miss_addr_i = vecs[i].addr; enable_i = vecs[i].en;
      cache_busy_i = vecs[i].busy; prefetch_ready_i = vecs[i].rdy; flush_i = 1'b0;
      #1;
      $display("vec %0d miss=%0b addr=%h en=%0b busy=%0b -> valid=%0b addr=%h occ=%0d",
               i, vecs[i].miss, vecs[i].addr, vecs[i].en, vecs[i].busy, valid_a, addr_a, occ_a);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_a}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_addr", i), addr_a, vecs[i].exp_addr);
      chk($sformatf("vec%0d_occ", i), {29'b0, occ_a}, {29'b0, vecs[i].exp_occ});
    end

    // Backpressure: fill the queue, stall the generator, then drain in order.
    do_reset();
    cycle_in(1'b1, 32'h100, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b1, 32'h300, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b1, 32'h500, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    chk("stall_occ_full", {29'b0, occ_a}, 32'd4);
    chk("stall_head", addr_a, 32'h110);
    order_exp[0] = 32'h110; order_exp[1] = 32'h120; order_exp[2] = 32'h310;
    order_exp[3] = 32'h320; order_exp[4] = 32'h510; order_exp[5] = 32'h520;
    idx = 0;
    prefetch_ready_i = 1'b1;
    for (int k = 0; k < 20 && idx < 6; k++) begin
      if (valid_a) begin
        $display("issue order %0d addr=%h", idx, addr_a);
        chk($sformatf("order%0d", idx), addr_a, order_exp[idx]);
        idx++;
      end
      cycle_in(1'b0, 32'h0, 1'b0);
    end
    chk("order_count", idx, 32'd6);
    cycle_in(1'b0, 32'h0, 1'b0);
    chk("drain_occ", {29'b0, occ_a}, 32'h0);

    // Flush with three queued entries and the generator mid-walk.
    do_reset();
    cycle_in(1'b1, 32'h1004, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b1, 32'h3000, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b1);
    chk("preflush_occ", {29'b0, occ_a}, 32'd3);
    cycle_in(1'b0, 32'h0, 1'b0);
    $display("after flush valid=%0b occ=%0d", valid_a, occ_a);
    chk("flush_valid", {31'b0, valid_a}, 32'h0);
    chk("flush_occ", {29'b0, occ_a}, 32'h0);
    cycle_in(1'b0, 32'h0, 1'b0);
    chk("flush_no_push", {29'b0, occ_a}, 32'h0);
    prefetch_ready_i = 1'b1;
    cycle_in(1'b1, 32'h1004, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    $display("post flush issue valid=%0b addr=%h", valid_a, addr_a);
    chk("reissue_valid", {31'b0, valid_a}, 32'h1);
    chk("reissue_addr", addr_a, 32'h1010);
    cycle_in(1'b0, 32'h0, 1'b0);
    chk("reissue_addr2", addr_a, 32'h1020);

    // Page boundary: A stops at the page, B may cross.
    do_reset();
    prefetch_ready_i = 1'b1;
    cycle_in(1'b1, 32'h1FF4, 1'b0);
    collect(6);
    chk("page_a_count", qa.size(), 32'd0);
    chk("page_b_count", qb.size(), 32'd2);
    if (qb.size() == 2) begin
      chk("page_b_0", qb[0], 32'h2000);
      chk("page_b_1", qb[1], 32'h2010);
    end
    cycle_in(1'b1, 32'h1FE0, 1'b0);
    collect(6);
    chk("page_a2_count", qa.size(), 32'd1);
    if (qa.size() == 1) chk("page_a2_0", qa[0], 32'h1FF0);
    chk("page_b2_count", qb.size(), 32'd1);

    // Reset in the middle of a walk behaves like power-up.
    prefetch_ready_i = 1'b0;
    cycle_in(1'b1, 32'h700, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    chk("midrst_pre_occ", {29'b0, occ_a}, 32'd2);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    #1;
    chk("midrst_valid", {31'b0, valid_a}, 32'h0);
    chk("midrst_addr", addr_a, 32'h0);
    chk("midrst_occ", {29'b0, occ_a}, 32'h0);
    rst_ni = 1'b1;
    cycle_in(1'b0, 32'h0, 1'b0);
    chk("midrst_idle_occ", {29'b0, occ_a}, 32'h0);
    prefetch_ready_i = 1'b1;
    cycle_in(1'b1, 32'h704, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    cycle_in(1'b0, 32'h0, 1'b0);
    $display("post reset issue valid=%0b addr=%h", valid_a, addr_a);
    chk("midrst_reissue", addr_a, 32'h710);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
